// File: rtl/fp32_div_pkg.sv
// Shared types and helpers for the FP32 divider sequencer: FSM states, operand
// classes, special constants and IEEE-754 field extraction.
package fp32_div_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

    typedef enum logic [1:0] {ZERO, NORM, INF, NAN} op_class_e;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    function automatic logic f_sign(input logic [31:0] x);
        return x[31];
    endfunction

    function automatic logic [7:0] f_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

    function automatic logic [22:0] f_man(input logic [31:0] x);
        return x[22:0];
    endfunction

    // Denormals (exp == 0) are flushed to zero.
    function automatic op_class_e f_class(input logic [31:0] x);
        if (f_exp(x) == 8'd0) begin
            return ZERO;
        end else if (f_exp(x) == 8'hFF) begin
            return (f_man(x) == 23'd0) ? INF : NAN;
        end else begin
            return NORM;
        end
    endfunction

endpackage

// File: rtl/fp32_special_case.sv
// Combinational IEEE-754 special-case screen for a single-precision divide.
// Results flagged is_special bypass the iterative core.
module fp32_special_case #(
    parameter logic [31:0] QNAN = 32'h7FC0_0000
) (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        is_special,
    output logic [31:0] special_q,
    output logic        invalid,
    output logic        dbz
);
    import fp32_div_pkg::*;

    op_class_e  ca;
    op_class_e  cb;
    logic       sign;
    logic [31:0] signed_inf;
    logic [31:0] signed_zero;

    always_comb begin
        ca          = f_class(a);
        cb          = f_class(b);
        sign        = f_sign(a) ^ f_sign(b);
        signed_inf  = {sign, POS_INF[30:0]};
        signed_zero = {sign, 31'd0};

        is_special = 1'b1;
        special_q  = 32'd0;
        invalid    = 1'b0;
        dbz        = 1'b0;

        if (ca == NAN || cb == NAN || (ca == ZERO && cb == ZERO) ||
            (ca == INF && cb == INF)) begin
            special_q = QNAN;
            invalid   = 1'b1;
        end else if (cb == ZERO) begin
            special_q = signed_inf;
            dbz       = (ca == NORM);
        end else if (ca == INF) begin
            special_q = signed_inf;
        end else if (ca == ZERO || cb == INF) begin
            special_q = signed_zero;
        end else begin
            is_special = 1'b0;
        end
    end

endmodule

// File: rtl/fp32_div_sequencer.sv
// Handshake and control wrapper around the iterative FP32 SRT divider core:
// screens special cases, loads the core, counts iterations, captures the quotient.
module fp32_div_sequencer #(
    parameter int unsigned ITERS = 13,
    parameter logic [31:0] QNAN  = 32'h7FC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_q,
    output logic        out_invalid,
    output logic        out_dbz,
    output logic [31:0] core_dividend,
    output logic [31:0] core_divisor,
    output logic        core_load_n,
    input  logic [31:0] core_quotient
);
    import fp32_div_pkg::*;

    localparam int unsigned CW = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] q_q, q_d;
    logic        inv_q, inv_d;
    logic        dbz_q, dbz_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] dvs_q, dvs_d;

    logic        sc_special;
    logic [31:0] sc_q;
    logic        sc_invalid;
    logic        sc_dbz;

    fp32_special_case #(
        .QNAN(QNAN)
    ) u_special (
        .a          (in_a),
        .b          (in_b),
        .is_special (sc_special),
        .special_q  (sc_q),
        .invalid    (sc_invalid),
        .dbz        (sc_dbz)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        inv_d   = inv_q;
        dbz_d   = dbz_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvd_d = in_a;
                    dvs_d = in_b;
                    if (sc_special) begin
                        q_d     = sc_q;
                        inv_d   = sc_invalid;
                        dbz_d   = sc_dbz;
                        state_d = DONE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                // Capture lands on the core's rounding cycle.
                if (cnt_q == LAST) begin
                    q_d     = core_quotient;
                    inv_d   = 1'b0;
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= 32'd0;
            inv_q   <= 1'b0;
            dbz_q   <= 1'b0;
            dvd_q   <= 32'd0;
            dvs_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            inv_q   <= inv_d;
            dbz_q   <= dbz_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
        end
    end

    always_comb begin
        in_ready      = (state_q == IDLE) && !rst;
        out_valid     = (state_q == DONE);
        out_q         = q_q;
        out_invalid   = inv_q;
        out_dbz       = dbz_q;
        core_dividend = dvd_q;
        core_divisor  = dvs_q;
        core_load_n   = !((state_q == LOAD) && !rst);
    end

endmodule

// File: tb/tb_fp32_div_sequencer.sv
// Directed bench for fp32_div_sequencer with a behavioural stand-in for the SRT core
// that only presents a valid quotient on its rounding cycle.
module tb_fp32_div_sequencer;

    localparam int ITERS = 13;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_q;
    logic        out_invalid;
    logic        out_dbz;
    logic [31:0] core_dividend;
    logic [31:0] core_divisor;
    logic        core_load_n;
    logic [31:0] core_quotient;

    int errors = 0;
    int checks = 0;
    int core_cnt = 0;

    always #5 clk = ~clk;

    fp32_div_sequencer #(
        .ITERS(ITERS),
        .QNAN (32'h7FC0_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_q        (out_q),
        .out_invalid  (out_invalid),
        .out_dbz      (out_dbz),
        .core_dividend(core_dividend),
        .core_divisor (core_divisor),
        .core_load_n  (core_load_n),
        .core_quotient(core_quotient)
    );

    // Core stand-in: count is 1 in the first cycle after load release, reaches ITERS
    // on the rounding cycle; any other cycle shows a poison value.
    function automatic logic [31:0] core_lookup(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        if (a == 32'h4120_0000 && b == 32'h40A0_0000) return 32'h4000_0000;
        return 32'hBADB_AD00;
    endfunction

    always @(posedge clk) begin
        if (!core_load_n) core_cnt <= 1;
        else              core_cnt <= core_cnt + 1;
    end

    assign core_quotient = (core_cnt == ITERS) ? core_lookup(core_dividend, core_divisor)
                                               : 32'hDEAD_BEEF;

    // Offer one pair in the current cycle (must be IDLE), then wait for out_valid.
    // lat = cycles from acceptance cycle T to first out_valid (-1 on timeout).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat,
                          output int load_cnt, output int load_at);
        lat      = -1;
        load_cnt = 0;
        load_at  = -1;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (!core_load_n) begin
                load_cnt++;
                load_at = n;
            end
            if (out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || core_load_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b load_n=%b want 0 0 1",
                     in_ready, out_valid, core_load_n);
        end
        checks++;
        if (out_q !== 32'd0 || out_invalid !== 1'b0 || out_dbz !== 1'b0 ||
            core_dividend !== 32'd0 || core_divisor !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: q=%h inv=%b dbz=%b dvd=%h dvs=%h want all zero",
                     out_q, out_invalid, out_dbz, core_dividend, core_divisor);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle_ready: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_normal();
        int lat, lc, la;
        out_ready = 1'b1;
        run_op(32'h40C0_0000, 32'h4000_0000, lat, lc, la);
        checks++;
        if (lat !== 15) begin
            errors++;
            $display("FAIL normal_latency: got %0d want 15", lat);
        end
        checks++;
        if (out_q !== 32'h4040_0000 || out_invalid !== 1'b0 || out_dbz !== 1'b0) begin
            errors++;
            $display("FAIL normal_result: q=%h inv=%b dbz=%b want 40400000 0 0",
                     out_q, out_invalid, out_dbz);
        end
        checks++;
        if (lc !== 1 || la !== 1) begin
            errors++;
            $display("FAIL normal_load_pulse: count=%0d at=%0d want 1 at 1", lc, la);
        end
        checks++;
        if (core_dividend !== 32'h40C0_0000 || core_divisor !== 32'h4000_0000) begin
            errors++;
            $display("FAIL normal_operands_held: dvd=%h dvs=%h want 40c00000 40000000",
                     core_dividend, core_divisor);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL normal_return_idle: in_ready=%b out_valid=%b want 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_dbz();
        int lat, lc, la;
        out_ready = 1'b1;
        run_op(32'h3F80_0000, 32'h0000_0000, lat, lc, la);
        checks++;
        if (lat !== 1 || lc !== 0) begin
            errors++;
            $display("FAIL dbz_latency: lat=%0d loads=%0d want 1 0", lat, lc);
        end
        checks++;
        if (out_q !== 32'h7F80_0000 || out_dbz !== 1'b1 || out_invalid !== 1'b0) begin
            errors++;
            $display("FAIL dbz_result: q=%h inv=%b dbz=%b want 7f800000 0 1",
                     out_q, out_invalid, out_dbz);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_specials();
        int lat, lc, la;
        out_ready = 1'b1;
        run_op(32'h0000_0000, 32'h8000_0000, lat, lc, la);
        checks++;
        if (lat !== 1 || out_q !== 32'h7FC0_0000 || out_invalid !== 1'b1 || out_dbz !== 1'b0) begin
            errors++;
            $display("FAIL zero_by_zero: lat=%0d q=%h inv=%b dbz=%b want 1 7fc00000 1 0",
                     lat, out_q, out_invalid, out_dbz);
        end
        @(posedge clk); #1;
        run_op(32'hBF80_0000, 32'h7F80_0000, lat, lc, la);
        checks++;
        if (lat !== 1 || out_q !== 32'h8000_0000 || out_invalid !== 1'b0 || out_dbz !== 1'b0) begin
            errors++;
            $display("FAIL finite_by_inf: lat=%0d q=%h inv=%b dbz=%b want 1 80000000 0 0",
                     lat, out_q, out_invalid, out_dbz);
        end
        @(posedge clk); #1;
        run_op(32'hFF80_0000, 32'h3F80_0000, lat, lc, la);
        checks++;
        if (lat !== 1 || out_q !== 32'hFF80_0000 || out_invalid !== 1'b0 || out_dbz !== 1'b0) begin
            errors++;
            $display("FAIL inf_by_finite: lat=%0d q=%h inv=%b dbz=%b want 1 ff800000 0 0",
                     lat, out_q, out_invalid, out_dbz);
        end
        @(posedge clk); #1;
        run_op(32'h7F80_0001, 32'h3F80_0000, lat, lc, la);
        checks++;
        if (out_q !== 32'h7FC0_0000 || out_invalid !== 1'b1 || lc !== 0) begin
            errors++;
            $display("FAIL nan_input: q=%h inv=%b loads=%0d want 7fc00000 1 0",
                     out_q, out_invalid, lc);
        end
        @(posedge clk); #1;
        run_op(32'h0000_0001, 32'h3F80_0000, lat, lc, la);
        checks++;
        if (out_q !== 32'h0000_0000 || out_invalid !== 1'b0 || out_dbz !== 1'b0) begin
            errors++;
            $display("FAIL denormal_flush: q=%h inv=%b dbz=%b want 00000000 0 0",
                     out_q, out_invalid, out_dbz);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int lat, lc, la;
        int bad = 0;
        out_ready = 1'b0;
        run_op(32'h40C0_0000, 32'h4000_0000, lat, lc, la);
        checks++;
        if (lat !== 15 || out_q !== 32'h4040_0000) begin
            errors++;
            $display("FAIL bp_first_result: lat=%0d q=%h want 15 40400000", lat, out_q);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_q !== 32'h4040_0000 ||
                out_invalid !== 1'b0 || out_dbz !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL bp_hold: %0d unstable cycles, want 0 (q=%h valid=%b ready=%b)",
                     bad, out_q, out_valid, in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, lc, la;
        int stray = 0;
        out_ready = 1'b1;
        in_a      = 32'h40C0_0000;
        in_b      = 32'h4000_0000;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || core_load_n !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_run: in_ready=%b out_valid=%b load_n=%b want 1 0 1",
                     in_ready, out_valid, core_load_n);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL rst_discard: %0d stray out_valid cycles want 0", stray);
        end
        run_op(32'h4120_0000, 32'h40A0_0000, lat, lc, la);
        checks++;
        if (lat !== 15 || out_q !== 32'h4000_0000) begin
            errors++;
            $display("FAIL rst_followup: lat=%0d q=%h want 15 40000000", lat, out_q);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int edge_n = 0;
        int acc_edges[2];
        logic [31:0] res[2];
        int n_acc = 0;
        int n_hs = 0;
        int hs_edge = -1;
        logic acc_pend, hs_pend;
        out_ready = 1'b1;
        in_a      = 32'h3F80_0000;
        in_b      = 32'h0000_0000;
        in_valid  = 1'b1;
        for (int i = 0; i < 60; i++) begin
            acc_pend = in_valid && in_ready;
            hs_pend  = out_valid && out_ready;
            if (hs_pend && n_hs < 2) res[n_hs] = out_q;
            @(posedge clk); #1;
            edge_n++;
            if (hs_pend) begin
                if (n_hs == 0) hs_edge = edge_n;
                n_hs++;
            end
            if (acc_pend) begin
                if (n_acc < 2) acc_edges[n_acc] = edge_n;
                n_acc++;
                if (n_acc == 1) begin
                    in_a = 32'h40C0_0000;
                    in_b = 32'h4000_0000;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (n_acc !== 2 || n_hs !== 2) begin
            errors++;
            $display("FAIL b2b_counts: accepts=%0d results=%0d want 2 2", n_acc, n_hs);
        end else begin
            checks++;
            if (acc_edges[1] !== hs_edge + 1) begin
                errors++;
                $display("FAIL b2b_accept_timing: second accept edge %0d want %0d",
                         acc_edges[1], hs_edge + 1);
            end
            checks++;
            if (res[0] !== 32'h7F80_0000 || res[1] !== 32'h4040_0000) begin
                errors++;
                $display("FAIL b2b_results: %h %h want 7f800000 40400000", res[0], res[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_dbz();
        test_specials();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp32_div_sequencer.md
Name: fp32_div_sequencer

Overview:
- Control and handshake stage wrapped around the iterative FP32 SRT divider core.
- Accepts an operand pair on a valid/ready interface, screens IEEE-754 special cases, and holds operands stable for the core.
- Pulses the core's active-low load input, counts the radix-4 iterations, captures the core quotient at the rounding cycle, and presents the result with valid/ready backpressure.
- Special-case results bypass the core entirely.

Parameters:
- ITERS, 13, core iterations from load release to quotient capture; must equal the core's rounding-cycle count.
- QNAN, 32'h7FC00000, canonical quiet NaN returned for invalid operations.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer can accept an operand pair
- in_a  in  32  dividend, IEEE-754 single
- in_b  in  32  divisor, IEEE-754 single
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_q  out  32  quotient, IEEE-754 single
- out_invalid  out  1  result is NaN due to invalid operation or NaN input
- out_dbz  out  1  finite nonzero divided by zero
- core_dividend  out  32  registered dividend to core
- core_divisor  out  32  registered divisor to core
- core_load_n  out  1  active-low load to core (drives core rst)
- core_quotient  in  32  core result

Behaviour:
- Reset values: in_ready=0 during rst, then 1 in IDLE; out_valid=0; out_q=0; out_invalid=0; out_dbz=0; core_load_n=1; core_dividend=0; core_divisor=0; iteration counter=0; state=IDLE.
- Reset is synchronous and active-high; it may be asserted in any state, including mid-RUN, and the in-flight operation is discarded with no output.
- Operand screening: exp==0 is treated as zero (denormals flushed, sign kept); exp==255 with mantissa 0 is inf; exp==255 with mantissa nonzero is NaN.
- Result sign = a.sign XOR b.sign for all non-NaN results.
- Special-case results:
  - either operand NaN, 0/0, or inf/inf -> QNAN, invalid=1
  - finite nonzero/0 -> signed inf (exp=255, mantissa=0), dbz=1
  - inf/finite or inf/0 -> signed inf
  - 0/nonzero or finite/inf -> signed zero
- State IDLE:
  - in_ready=1.
  - On in_valid: capture in_a/in_b into the core operand registers.
  - If the pair is a special case, register the special result and go to DONE.
  - Otherwise go to LOAD.
- State LOAD: exactly one cycle; core_load_n=0; counter cleared; go to RUN.
- State RUN:
  - core_load_n=1; counter increments each cycle.
  - When counter==ITERS-1, register core_quotient into out_q and go to DONE.
  - The capture cycle aligns with the core's internal count reaching ITERS.
- State DONE:
  - out_valid=1; out_q and flags held stable until out_ready.
  - On out_valid&&out_ready, return to IDLE.
- Latency, measured from the acceptance cycle T (in_valid&&in_ready):
  - Normal operation: out_valid is first high at T+2+ITERS (15 cycles at the default).
  - Special case: out_valid is first high at T+1.
- Throughput: no overlap. in_ready=0 outside IDLE, so at most one operation is in flight.
- Core operand registers are held constant from LOAD through DONE.

Decomposition:
- Package fp32_div_pkg:
  - state enum {IDLE, LOAD, RUN, DONE}
  - operand class enum {ZERO, NORM, INF, NAN}
  - QNAN and POS_INF constants
  - field-extract functions for sign, exp and mantissa
- Sub-module fp32_special_case (combinational): classifies both operands and outputs is_special, special_q, invalid and dbz.
- The FSM, counter and handshake logic live in the top module.

Test Plan:
- 40C00000 / 40000000 (6.0/2.0), out_ready=1 -> out_q=40400000 at T+15; invalid=0, dbz=0; core_load_n low only at T+1.
- 3F800000 / 00000000 -> out_q=7F800000, dbz=1, out_valid at T+1; core_load_n never asserted.
- 00000000 / 80000000 -> 7FC00000, invalid=1. Also BF800000 / 7F800000 -> 80000000, flags 0.
- Backpressure: 40C00000 / 40000000 with out_ready=0 for 10 cycles after out_valid -> out_q held at 40400000, in_ready=0 throughout; both flags hold; IDLE one cycle after out_ready is raised.
- rst asserted at T+6 mid-RUN -> next cycle state IDLE, out_valid=0, in_ready=1; a following 41200000 / 40A00000 (10.0/5.0) yields 40000000.
- Back-to-back: in_valid held high with two pairs -> second pair accepted only in the cycle after the first handshake completes; no result lost or duplicated.
